// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: address width,
// the hardwired zero register and the arbiter FSM state encoding.
package rf_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        WB_PRI   = 1'b0,
        MD_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage and the multi-cycle mul/div unit, with anti-starvation for mul/div.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int MD_MAX_WAIT = 4,
    parameter int DATA_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wb_ready,

    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  md_ready,

    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,

    output logic                  md_forced
);

    // Handshake: a request transfers on a rising edge where valid && ready;
    // the requester holds valid/addr/data stable until then. ready is purely
    // a function of state and the two valids, never of downstream pressure.

    localparam logic [2:0] MAX_CNT = 3'(MD_MAX_WAIT);

    arb_state_e state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       wb_fire, md_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_PRI;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        wb_ready = 1'b0;
        md_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                WB_PRI: begin
                    wb_ready = wb_valid;
                    md_ready = md_valid && !wb_valid;
                end
                MD_FORCE: begin
                    md_ready = md_valid;
                    wb_ready = wb_valid && !md_valid;
                end
                default: begin
                    wb_ready = 1'b0;
                    md_ready = 1'b0;
                end
            endcase
        end
    end

    assign wb_fire = wb_valid && wb_ready;
    assign md_fire = md_valid && md_ready;

    // Force is decided from the updated count so the grant lands on the
    // cycle right after the MD_MAX_WAIT-th stalled cycle.
    always_comb begin
        wait_d  = 3'd0;
        state_d = state_q;
        if (md_valid && !md_ready) begin
            wait_d = (wait_q == MAX_CNT) ? wait_q : wait_q + 3'd1;
        end
        case (state_q)
            WB_PRI: begin
                if (wait_d == MAX_CNT) state_d = MD_FORCE;
            end
            MD_FORCE: begin
                if (md_fire || !md_valid) state_d = WB_PRI;
            end
            default: state_d = WB_PRI;
        endcase
    end

    assign md_forced = (state_q == MD_FORCE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= ZERO_REG;
            rf_wdata <= '0;
        end else if (wb_fire) begin
            rf_we    <= (wb_addr != ZERO_REG);
            rf_waddr <= wb_addr;
            rf_wdata <= wb_data;
        end else if (md_fire) begin
            rf_we    <= (md_addr != ZERO_REG);
            rf_waddr <= md_addr;
            rf_wdata <= md_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model and an expected-write queue.
module tb_rf_write_arbiter;

    localparam int MAXW = 4;
    localparam int DW   = 32;
    localparam int EW   = 1 + 5 + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, md_valid;
    logic [4:0]    wb_addr, md_addr;
    logic [DW-1:0] wb_data, md_data;
    logic          wb_ready, md_ready;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          md_forced;

    always #5 clk = ~clk;

    rf_write_arbiter #(.MD_MAX_WAIT(MAXW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .md_valid  (md_valid),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .md_ready  (md_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .md_forced (md_forced)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard: one entry per cycle {we, addr, data} the outputs must show next cycle.
    logic [EW-1:0] exp_q[$];

    // Model state: consecutive md stall cycles, force flag, last written address/data.
    int            m_run    = 0;
    bit            m_forced = 1'b0;
    logic [4:0]    m_addr   = '0;
    logic [DW-1:0] m_data   = '0;
    bit            m_prev_nz = 1'b0;
    logic          m_wbr, m_mdr;

    logic          o_wbr, o_mdr, o_forced, o_we;
    logic [4:0]    o_addr;
    logic [DW-1:0] o_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic step(input logic r,
                        input logic wv, input logic [4:0] wa, input logic [DW-1:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [DW-1:0] md);
        logic [EW-1:0] e;
        @(negedge clk);
        rst = r;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        md_valid = mv; md_addr = ma; md_data = md;
        #1;
        o_wbr = wb_ready; o_mdr = md_ready; o_forced = md_forced;
        o_we = rf_we; o_addr = rf_waddr; o_data = rf_wdata;

        if (r) begin
            m_wbr = 1'b0; m_mdr = 1'b0;
        end else if (m_forced) begin
            m_mdr = mv; m_wbr = wv && !mv;
        end else begin
            m_wbr = wv; m_mdr = mv && !wv;
        end

        chk("wb_ready", o_wbr, m_wbr);
        chk("md_ready", o_mdr, m_mdr);
        chk("md_forced", o_forced, m_forced);
        chk("ready_mutex", o_wbr && o_mdr, 1'b0);
        chk("we_implies_xfer", o_we && !m_prev_nz, 1'b0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", o_we, e[EW-1]);
            chk("rf_waddr", o_addr, e[EW-2 -: 5]);
            chk("rf_wdata", o_data, e[DW-1:0]);
        end

        if (r) begin
            m_run = 0; m_forced = 1'b0;
            m_addr = '0; m_data = '0; m_prev_nz = 1'b0;
            exp_q.push_back('0);
        end else begin
            if (mv && !m_mdr) m_run = (m_run < MAXW) ? m_run + 1 : MAXW;
            else              m_run = 0;
            m_forced = (m_run >= MAXW);
            if (m_wbr) begin
                m_addr = wa; m_data = wd; m_prev_nz = (wa != 0);
                exp_q.push_back({wa != 5'd0, wa, wd});
            end else if (m_mdr) begin
                m_addr = ma; m_data = md; m_prev_nz = (ma != 0);
                exp_q.push_back({ma != 5'd0, ma, md});
            end else begin
                m_prev_nz = 1'b0;
                exp_q.push_back({1'b0, m_addr, m_data});
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    bit            p_wb, p_md;
    logic [4:0]    p_wa, p_ma;
    logic [DW-1:0] p_wd, p_md_d;

    initial begin
        rst = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;

        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        chk("rst_we", o_we, 1'b0);
        chk("rst_waddr", o_addr, 5'd0);
        chk("rst_wdata", o_data, 32'd0);
        chk("rst_forced", o_forced, 1'b0);
        idle();

        // Single writeback write.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        chk("single_wbr", o_wbr, 1'b1);
        idle();
        chk("single_we", o_we, 1'b1);
        chk("single_addr", o_addr, 5'd5);
        chk("single_data", o_data, 32'hDEADBEEF);

        // Starvation: md waits four cycles, then is forced through.
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 5'd3, 32'(c), 1'b1, 5'd9, 32'h99);
            chk("starve_mdr_low", o_mdr, 1'b0);
        end
        step(1'b0, 1'b1, 5'd3, 32'd4, 1'b1, 5'd9, 32'h99);
        chk("force_flag", o_forced, 1'b1);
        chk("force_mdr", o_mdr, 1'b1);
        chk("force_wbr", o_wbr, 1'b0);
        step(1'b0, 1'b1, 5'd3, 32'd4, 1'b0, 5'd0, '0);
        chk("force_waddr", o_addr, 5'd9);
        chk("force_wdata", o_data, 32'h99);
        chk("force_exit", o_forced, 1'b0);
        idle();
        idle();

        // Zero register write is accepted but suppressed.
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h1234);
        chk("zero_mdr", o_mdr, 1'b1);
        idle();
        chk("zero_we", o_we, 1'b0);

        // Same-address serialisation.
        step(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        chk("same_wbr", o_wbr, 1'b1);
        chk("same_mdr", o_mdr, 1'b0);
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hB);
        chk("same_first", o_data, 32'hA);
        chk("same_mdr2", o_mdr, 1'b1);
        idle();
        chk("same_second", o_data, 32'hB);
        chk("same_we2", o_we, 1'b1);
        idle();

        // Reset mid-contention with the stall count at 3.
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 5'd3, 32'(c), 1'b1, 5'd9, 32'h77);
        step(1'b1, 1'b1, 5'd3, 32'd9, 1'b1, 5'd9, 32'h77);
        chk("rstmid_wbr", o_wbr, 1'b0);
        chk("rstmid_mdr", o_mdr, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, 5'd3, 32'(c), 1'b1, 5'd9, 32'h77);
            if (c == 0) chk("rstmid_we", o_we, 1'b0);
            chk("rstmid_grant", o_mdr, (c == 4) ? 1'b1 : 1'b0);
        end
        idle();

        // Randomized traffic; requesters hold until transferred, even across reset.
        p_wb = 1'b0; p_md = 1'b0;
        p_wa = '0; p_ma = '0; p_wd = '0; p_md_d = '0;
        for (int n = 0; n < 3000; n++) begin
            logic r;
            if (!p_wb && $urandom_range(0, 9) < 7) begin
                p_wb = 1'b1; p_wa = 5'($urandom_range(0, 31)); p_wd = $urandom;
            end
            if (!p_md && $urandom_range(0, 9) < 3) begin
                p_md = 1'b1; p_ma = 5'($urandom_range(0, 31)); p_md_d = $urandom;
            end
            r = ($urandom_range(0, 199) == 0);
            step(r, p_wb, p_wa, p_wd, p_md, p_ma, p_md_d);
            if (m_wbr) p_wb = 1'b0;
            if (m_mdr) p_md = 1'b0;
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter MD_MAX_WAIT, default 4 (range 1-7): the number of consecutive stalled cycles after which the mul/div requester gets forced priority.
REQ-002 The block SHALL have parameter DATA_W, default 32: the write-data width.
REQ-003 The block SHALL have port clk, input, 1: the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port wb_valid, input, 1: the pipeline writeback stage requests a register write.
REQ-006 The block SHALL have port wb_addr, input, 5: the writeback destination register.
REQ-007 The block SHALL have port wb_data, input, DATA_W: the writeback data.
REQ-008 The block SHALL have port wb_ready, output, 1: the writeback request is accepted this cycle (combinational).
REQ-009 The block SHALL have port md_valid, input, 1: the multi-cycle mul/div unit requests a register write.
REQ-010 The block SHALL have port md_addr, input, 5: the mul/div destination register.
REQ-011 The block SHALL have port md_data, input, DATA_W: the mul/div data.
REQ-012 The block SHALL have port md_ready, output, 1: the mul/div request is accepted this cycle (combinational).
REQ-013 The block SHALL have port rf_we, output, 1: register-file write enable (registered).
REQ-014 The block SHALL have port rf_waddr, output, 5: register-file write address (registered).
REQ-015 The block SHALL have port rf_wdata, output, DATA_W: register-file write data (registered).
REQ-016 The block SHALL have port md_forced, output, 1: the arbiter is in state MD_FORCE (debug/perf).

Function
REQ-017 A transfer SHALL occur on a requester when valid && ready are both high at a clock edge; valid, addr and data SHALL be held stable by the requester until that transfer.
REQ-018 At most one requester SHALL be granted per cycle; wb_ready and md_ready SHALL never both be high.
REQ-019 The FSM SHALL have two states: WB_PRI (reset state) and MD_FORCE.
REQ-020 In WB_PRI: wb_ready = wb_valid; md_ready = md_valid && !wb_valid.
REQ-021 In MD_FORCE: md_ready = md_valid; wb_ready = wb_valid && !md_valid.
REQ-022 The wait counter (3 bits) SHALL increment each cycle that md_valid && !md_ready, and SHALL clear on an md transfer or when md_valid is low; it SHALL saturate at MD_MAX_WAIT.
REQ-023 WB_PRI SHALL move to MD_FORCE when the wait counter equals MD_MAX_WAIT; MD_FORCE SHALL return to WB_PRI after an md transfer, or when md_valid is low.
REQ-024 Latency SHALL be one cycle: a transfer at edge N drives rf_we=1, rf_waddr and rf_wdata from the granted requester during cycle N+1.
REQ-025 A transfer with address 0 SHALL complete the handshake but SHALL produce rf_we=0 in cycle N+1.
REQ-026 In a cycle with no transfer, rf_we SHALL be 0 in the following cycle; rf_waddr and rf_wdata SHALL hold their previous values.
REQ-027 When both requesters target the same address, the writes SHALL be serialised in grant order; no merging or dropping is allowed.
REQ-028 Readiness SHALL NOT depend on any downstream backpressure; the register-file port always accepts.

Reset
REQ-029 While rst is high at an edge: rf_we=0, rf_waddr=0, rf_wdata=0, FSM=WB_PRI, wait counter=0, md_forced=0.
REQ-030 While rst is high, wb_ready and md_ready SHALL be 0, so no transfer occurs.
REQ-031 A request pending when rst asserts SHALL be neither accepted nor written; the requester retries after reset.

Structure
REQ-032 The shared package SHALL hold REG_ADDR_W=5, ZERO_REG=5'd0 and the FSM state enum {WB_PRI, MD_FORCE}.
REQ-033 The block SHALL be a single module; no sub-module is required.
REQ-034 The block SHALL drive the register file's RegWrite, Waddr and WB inputs directly.

Verification
REQ-035 Single write: wb_valid=1, addr=5, data=0xDEADBEEF for one cycle -> wb_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-036 Contention with starvation: wb_valid held high and md_valid=1 (addr=9) from cycle 0 with MD_MAX_WAIT=4 -> md_ready=0 for cycles 0-3; in cycle 4 md_forced=1, md_ready=1, wb_ready=0; cycle 5 shows rf_waddr=9; cycle 5 returns to WB_PRI.
REQ-037 Zero register: md_valid=1, addr=0, data=0x1234 -> md_ready=1; next cycle rf_we=0.
REQ-038 Same-address serialisation: wb and md both valid for addr=7 (wb data 0xA, md data 0xB) -> cycle N+1 writes 0xA; md is granted at cycle N+1 and writes 0xB at cycle N+2.
REQ-039 Reset mid-operation: rst=1 while both requesters are valid and the counter is 3 -> both readys 0, rf_we=0 next cycle; after rst deasserts, the counter restarts from 0 (first forced grant 4 cycles later).
REQ-040 Invariant check: in every cycle, !(wb_ready && md_ready), and rf_we implies a transfer with nonzero address in the prior cycle.
